// File: rtl/parallel_crc16_if.sv
// Codeword bus between the message source and the CRC stage.
// The source drives data_in and receives the registered codeword on data_out.
interface parallel_crc16_if #(
  parameter int DATA_W = 34,
  parameter int CRC_W  = 16
);
  logic [DATA_W-1:0]       data_in;
  logic [DATA_W+CRC_W-1:0] data_out;

  modport master (output data_in, input data_out);
  modport slave  (input data_in, output data_out);
endinterface

// File: rtl/parallel_crc16.sv
// Single-cycle parallel CRC generator: registers {data_in, crc(data_in)} every clock.
// The bit-serial MSB-first CRC is unrolled into one combinational XOR cone.
module parallel_crc16 #(
  parameter int               DATA_W = 34,
  parameter int               CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = 16'h8005,
  parameter logic [CRC_W-1:0] INIT   = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  parallel_crc16_if.slave   bus
);

  logic [CRC_W-1:0]        w_crc;
  logic [DATA_W+CRC_W-1:0] r_data_out;

  // Preset to INIT for every word, so no state carries between words.
  function automatic logic [CRC_W-1:0] crc_calc(input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = INIT;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = d[i] ^ c[CRC_W-1];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
    end
    return c;
  endfunction

  always_comb begin
    w_crc = crc_calc(bus.data_in);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
    end else begin
      r_data_out <= {bus.data_in, w_crc};
    end
  end

  assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_parallel_crc16.sv
// Self-checking bench: directed table, reset corner cases, random stream,
// linearity pairs and receiver-side remainder checks.
module tb_parallel_crc16;

  localparam int DW = 34;
  localparam int CW = 16;
  localparam int TW = DW + CW;
  localparam logic [CW-1:0] POLY = 16'h8005;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  parallel_crc16_if #(.DATA_W(DW), .CRC_W(CW)) bus ();

  parallel_crc16 #(.DATA_W(DW), .CRC_W(CW), .POLY(POLY), .INIT(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] din;
    logic [TW-1:0] exp;
  } vec_t;

  // Polynomial long division: (d * x^16) mod P, on the full 50-bit dividend.
  function automatic logic [CW-1:0] ref_crc(input logic [DW-1:0] d);
    logic [TW-1:0] m;
    logic [TW-1:0] g;
    m = {d, {CW{1'b0}}};
    for (int i = TW - 1; i >= CW; i--) begin
      if (m[i]) begin
        g = {{(TW-CW-1){1'b0}}, 1'b1, POLY} << (i - CW);
        m = m ^ g;
      end
    end
    return m[CW-1:0];
  endfunction

  // Receiver: bit-serial CRC across all 50 codeword bits.
  function automatic logic [CW-1:0] rx_crc(input logic [TW-1:0] w);
    logic [CW-1:0] c;
    logic          fb;
    c = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      fb = w[i] ^ c[CW-1];
      c  = {c[CW-2:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [DW-1:0] rnd34();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_nz(input string name, input logic [CW-1:0] act);
    n_cmp++;
    if (act === 16'h0000) begin
      n_bad++;
      $display("FAIL %s: got %h expected nonzero", name, act);
    end
  endtask

  // Drive a word away from the edge, clock it in, sample 1 ns after the edge.
  task automatic apply(input logic [DW-1:0] d, output logic [TW-1:0] q);
    bus.data_in = d;
    @(posedge clk);
    #1;
    q = bus.data_out;
  endtask

  vec_t          tbl[5];
  logic [TW-1:0] q;
  logic [TW-1:0] qa;
  logic [TW-1:0] qb;
  logic [TW-1:0] flipped;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  int            k;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tbl[0] = '{din: 34'h0,         exp: 50'h0};
    tbl[1] = '{din: 34'h1,         exp: {34'h1, 16'h8005}};
    tbl[2] = '{din: 34'h2,         exp: {34'h2, 16'h800F}};
    tbl[3] = '{din: 34'h3,         exp: {34'h3, 16'h000A}};
    tbl[4] = '{din: 34'h2_4924_9249, exp: {34'h2_4924_9249, ref_crc(34'h2_4924_9249)}};

    // Reset held with clock running: output stays zero.
    reset       = 1'b0;
    bus.data_in = 34'h2_4924_9249;
    #2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", bus.data_out, 50'h0);
      $display("reset cycle %0d data_out=%h", i, bus.data_out);
    end
    reset = 1'b1;

    // Directed table; the first entry is the first edge after release.
    for (int i = 0; i < 5; i++) begin
      apply(tbl[i].din, q);
      check("table", q, tbl[i].exp);
      $display("table din=%h data_out=%h exp=%h", tbl[i].din, q, tbl[i].exp);
    end

    // Mid-stream asynchronous reset clears between edges.
    apply(34'h1, q);
    check("pre_async", q, {34'h1, 16'h8005});
    #2;
    reset = 1'b0;
    #1;
    check("async_clear", bus.data_out, 50'h0);
    $display("async reset data_out=%h", bus.data_out);
    bus.data_in = 34'h2;
    @(posedge clk);
    #1;
    check("async_hold", bus.data_out, 50'h0);
    reset = 1'b1;
    apply(34'h2, q);
    check("post_release", q, {34'h2, 16'h800F});
    $display("post release data_out=%h", q);

    // Random streaming with receiver check and single-bit corruption.
    for (int i = 0; i < 300; i++) begin
      a = rnd34();
      apply(a, q);
      check("stream", q, {a, ref_crc(a)});
      check("rx_zero", {34'h0, rx_crc(q)}, 50'h0);
      k = $urandom_range(TW - 1, 0);
      flipped = q;
      flipped[k] = ~flipped[k];
      check_nz("rx_flip", rx_crc(flipped));
      if (i < 8) $display("stream din=%h data_out=%h flip_bit=%0d", a, q, k);
    end

    // Linearity over random pairs, using the DUT's own outputs.
    for (int i = 0; i < 1000; i++) begin
      a = rnd34();
      b = rnd34();
      apply(a, qa);
      apply(b, qb);
      apply(a ^ b, q);
      check("linear", {34'h0, q[CW-1:0]}, {34'h0, qa[CW-1:0] ^ qb[CW-1:0]});
      check("linear_ref", q, {a ^ b, ref_crc(a ^ b)});
      if (i < 4) $display("linear a=%h b=%h crc_ab=%h", a, b, q[CW-1:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
